imem_boot_loader: RTL and testbench
===================================

# imem_boot_loader

Boot-time controller that fills the instruction memory from a byte stream and holds the core in reset until the image is complete. It sits between a byte source (UART receiver or debug port) and the write port of the byte-addressed instruction memory (`BYTE_WIDTH`-bit cells, `N_INSTR*BYTE_WIDTH` entries). It sequences a length header, the payload writes and core-reset release. Fetch reads are untouched; this block only drives the write side and `cpu_rst`.

## Interface
- `N`, 32, address/bit width of the core
- `N_INSTR`, 32, memory sizing factor; memory depth `MEM_BYTES = N_INSTR*BYTE_WIDTH` bytes
- `BYTE_WIDTH`, 8, width of one memory cell and one stream beat

- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a load (level sampled in IDLE/RUN/ERROR)
- `run`  in  1  release core without loading (sampled in IDLE only)
- `rx_data`  in  BYTE_WIDTH  stream byte
- `rx_valid`  in  1  stream byte valid
- `rx_ready`  out  1  block accepts byte this cycle
- `mem_we`  out  1  memory write enable (registered)
- `mem_waddr`  out  N  memory byte address (registered)
- `mem_wdata`  out  BYTE_WIDTH  memory write data (registered)
- `cpu_rst`  out  1  core reset, active-high (registered)
- `busy`  out  1  load in progress
- `done`  out  1  core released (state RUN)
- `error`  out  1  load rejected (state ERROR)

## Operation
- Handshake: byte accepted on any cycle with `rx_valid && rx_ready`. `rx_valid` while `rx_ready=0` is ignored; no byte is lost or buffered.
- States:
  - IDLE: `cpu_rst=1`, `rx_ready=0`. `start` goes to LEN_LO. Otherwise `run` goes to RUN. `start` wins if both are high.
  - LEN_LO: `rx_ready=1`. Accepted byte is L[7:0]; go to LEN_HI.
  - LEN_HI: `rx_ready=1`. Accepted byte is L[15:8]. If L==0 or L>MEM_BYTES, go to ERROR; else go to DATA with the address counter at 0.
  - DATA: `rx_ready=1`. Each accepted byte issues one write at the current address, and the address increments by 1. After the L-th byte, go to CSUM (macro defined) or FLUSH.
  - FLUSH: one cycle, `rx_ready=0`, lets the last write commit. Then go to RUN.
  - RUN: `cpu_rst=0`, `done=1`. `start` goes to LEN_LO and reasserts `cpu_rst` in the next cycle.
  - ERROR: `error=1`, `cpu_rst=1`. Only `start` (retry to LEN_LO) or `rst` leaves this state.
- `busy=1` in LEN_LO, LEN_HI, DATA, CSUM and FLUSH.
- Byte counter and address counter are 16-bit internally; `mem_waddr` is zero-extended to N. The address never exceeds `L-1`, so memory never wraps.
- Memory cells beyond L keep their prior contents.

## Timing
- Reset values: state IDLE, `rx_ready=0`, `mem_we=0`, `mem_waddr=0`, `mem_wdata=0`, `cpu_rst=1`, `busy=0`, `done=0`, `error=0`, counters 0.
- `rst` mid-load aborts immediately, with all outputs at reset values on the next cycle. Partially written memory is not cleared.
- Write latency: a byte accepted in cycle t drives `mem_we=1` with its address and data in cycle t+1 only. Back-to-back bytes give back-to-back writes (one write per cycle peak).
- Release: final payload byte (or checksum byte) accepted in cycle t:
  - cycle t+1: FLUSH, last write
  - cycle t+2: `cpu_rst=0`, `done=1`
- Header rejection: `error=1` in the cycle after the LEN_HI handshake; `busy` drops the same cycle.
- `start` in RUN: `cpu_rst=1`, `done=0`, `busy=1` on the next cycle.
- Output registers drive `done`, `busy`, `error` and `cpu_rst`. `rx_ready` is decoded from state.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - After DATA the block enters CSUM (`rx_ready=1`) and accepts one checksum byte, which is not written to memory.
  - An 8-bit running sum of payload bytes plus the checksum byte must equal 0 mod 256; match goes to FLUSH, mismatch goes to ERROR the next cycle.
  - `cpu_rst` stays 1 on mismatch.
- Undefined: CSUM state and the sum register are absent; DATA goes directly to FLUSH.

## Test plan
- Reset then `run=1`: `cpu_rst` falls the next cycle, `done=1`, and `mem_we` never asserts.
- `start`, then header 0x04,0x00, then payload 0x13,0x00,0x00,0x00 sent back-to-back: writes to addresses 0..3 with those bytes in consecutive cycles; `cpu_rst=0` two cycles after the last byte.
- Header 0x00,0x00 and header 0x01,0x01 (257 > 256): `error=1`, no writes. A following `start` plus a valid load succeeds.
- Payload with `rx_valid` toggling randomly (gaps): writes match bytes and addresses exactly, and no write occurs in a gap cycle.
- `rst` asserted after 2 of 4 payload bytes: outputs return to reset values next cycle, then a full reload completes correctly.
- With `IMEM_LOADER_CHECKSUM_EN`, payload 0x01,0x02:
  - checksum 0xFD: `done=1`
  - checksum 0xFE: `error=1`, `cpu_rst=1`

Source files
------------

// File: rtl/imem_boot_loader_if.sv
// Stream and memory-write bundle for imem_boot_loader.
//   rx_data/rx_valid/rx_ready : byte stream (valid/ready handshake)
//   mem_we/mem_waddr/mem_wdata : byte-wide instruction memory write port
// master modport is the loader side; slave is the source/memory side.
interface imem_boot_loader_if #(
  parameter int unsigned N          = 32,
  parameter int unsigned BYTE_WIDTH = 8
) ();
  logic [BYTE_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  mem_we;
  logic [N-1:0]          mem_waddr;
  logic [BYTE_WIDTH-1:0] mem_wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_waddr, mem_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a 16-bit little-endian length header followed by the payload bytes,
// writes them to instruction memory starting at address 0, then releases the core reset.
// Ports:
//   clk_i, rst_i (synchronous, active-high)
//   start_i   : begin a load (IDLE/RUN/ERROR)
//   run_i     : release core without loading (IDLE only)
//   bus_io    : stream input and memory write port (master modport)
//   cpu_rst_o : core reset, busy_o : load in progress, done_o : core running,
//   error_o   : header or checksum rejected
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing checksum byte
// such that the 8-bit sum of payload and checksum is zero.
module imem_boot_loader #(
  parameter int unsigned N          = 32,
  parameter int unsigned N_INSTR    = 32,
  parameter int unsigned BYTE_WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               run_i,
  imem_boot_loader_if.master bus_io,
  output logic               cpu_rst_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               error_o
);

  localparam int unsigned MemBytes  = N_INSTR * BYTE_WIDTH;
  localparam logic [16:0] MemBytesW = 17'(MemBytes);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLenLo = 3'd1,
    StLenHi = 3'd2,
    StData  = 3'd3,
    StFlush = 3'd4,
    StRun   = 3'd5,
    StError = 3'd6
`ifdef IMEM_LOADER_CHECKSUM_EN
    , StCsum = 3'd7
`endif
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           addr_q, addr_d;
  logic                  we_q, we_d;
  logic [N-1:0]          waddr_q, waddr_d;
  logic [BYTE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  cpu_rst_q, busy_q, done_q, error_q;
  logic                  rx_ready;
  logic                  accept;
  logic [7:0]            rx_byte;
  logic [15:0]           len_hdr;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            sum_q, sum_d;
  logic [7:0]            sum_total;
`endif

  always_comb begin
    rx_ready = 1'b0;
    unique case (state_q)
      StLenLo, StLenHi, StData: rx_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCsum:                   rx_ready = 1'b1;
`endif
      default:                  rx_ready = 1'b0;
    endcase
  end

  assign accept  = bus_io.rx_valid && rx_ready;
  assign rx_byte = bus_io.rx_data[7:0];

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    addr_d   = addr_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    len_hdr  = {rx_byte, len_lo_q};
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
    sum_total = sum_q + rx_byte;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i)    state_d = StLenLo;
        else if (run_i) state_d = StRun;
      end
      StLenLo: begin
        if (accept) begin
          len_lo_d = rx_byte;
          state_d  = StLenHi;
        end
      end
      StLenHi: begin
        if (accept) begin
          if (len_hdr == 16'd0 || {1'b0, len_hdr} > MemBytesW) begin
            state_d = StError;
          end else begin
            len_d   = len_hdr;
            addr_d  = 16'd0;
            state_d = StData;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_d   = 8'd0;
`endif
          end
        end
      end
      StData: begin
        if (accept) begin
          we_d    = 1'b1;
          waddr_d = {{(N-16){1'b0}}, addr_d};
          wdata_d = bus_io.rx_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d   = sum_total;
`endif
          // Stop at L-1 so the address never leaves the loaded image.
          if (addr_q == len_q - 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = StCsum;
`else
            state_d = StFlush;
`endif
          end else begin
            addr_d = addr_q + 16'd1;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCsum: begin
        if (accept) state_d = (sum_total == 8'd0) ? StFlush : StError;
      end
`endif
      StFlush: state_d = StRun;
      StRun:   if (start_i) state_d = StLenLo;
      StError: if (start_i) state_d = StLenLo;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      len_lo_q  <= 8'd0;
      len_q     <= 16'd0;
      addr_q    <= 16'd0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      len_lo_q  <= len_lo_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      // Status outputs are decoded from the next state so they line up with state_q.
      cpu_rst_q <= (state_d != StRun);
      done_q    <= (state_d == StRun);
      error_q   <= (state_d == StError);
      busy_q    <= (state_d == StLenLo) || (state_d == StLenHi) || (state_d == StData) ||
`ifdef IMEM_LOADER_CHECKSUM_EN
                   (state_d == StCsum) ||
`endif
                   (state_d == StFlush);
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  assign bus_io.rx_ready  = rx_ready;
  assign bus_io.mem_we    = we_q;
  assign bus_io.mem_waddr = waddr_q;
  assign bus_io.mem_wdata = wdata_q;
  assign cpu_rst_o        = cpu_rst_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign error_o          = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed testbench for imem_boot_loader.
module tb_imem_boot_loader;

  logic clk;
  logic rst;
  logic start;
  logic run;
  logic cpu_rst;
  logic busy;
  logic done;
  logic error;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;

  logic [7:0] mem_model [0:255];
  logic [7:0] pay [0:255];
  logic [7:0] run_sum;

  imem_boot_loader_if #(.N(32), .BYTE_WIDTH(8)) bus ();

  imem_boot_loader #(
    .N          (32),
    .N_INSTR    (32),
    .BYTE_WIDTH (8)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .run_i     (run),
    .bus_io    (bus.master),
    .cpu_rst_o (cpu_rst),
    .busy_o    (busy),
    .done_o    (done),
    .error_o   (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image as the write port would commit it.
  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) begin
      mem_model[bus.mem_waddr[7:0]] <= bus.mem_wdata;
      wr_count <= wr_count + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string p);
    check({p, ".rx_ready"}, 32'(bus.rx_ready), 32'd0);
    check({p, ".mem_we"}, 32'(bus.mem_we), 32'd0);
    check({p, ".mem_waddr"}, bus.mem_waddr, 32'd0);
    check({p, ".mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    check({p, ".cpu_rst"}, 32'(cpu_rst), 32'd1);
    check({p, ".busy"}, 32'(busy), 32'd0);
    check({p, ".done"}, 32'(done), 32'd0);
    check({p, ".error"}, 32'(error), 32'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_header(input logic [7:0] lo, input logic [7:0] hi);
    run_sum      = 8'd0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = lo;
    tick();
    bus.rx_data  = hi;
    tick();
  endtask

  // Back-to-back payload: each byte must appear on the write port the next cycle.
  task automatic send_stream(input int n);
    for (int i = 0; i < n; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = pay[i];
      run_sum      = run_sum + pay[i];
      tick();
      check($sformatf("wr%0d.we", i), 32'(bus.mem_we), 32'd1);
      check($sformatf("wr%0d.addr", i), bus.mem_waddr, 32'(i));
      check($sformatf("wr%0d.data", i), 32'(bus.mem_wdata), 32'(pay[i]));
    end
  endtask

  task automatic finish_load(input string p);
`ifdef IMEM_LOADER_CHECKSUM_EN
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'(8'd0 - run_sum);
    tick();
`endif
    bus.rx_valid = 1'b0;
    check({p, ".flush_busy"}, 32'(busy), 32'd1);
    check({p, ".flush_cpu_rst"}, 32'(cpu_rst), 32'd1);
    tick();
    check({p, ".cpu_rst"}, 32'(cpu_rst), 32'd0);
    check({p, ".done"}, 32'(done), 32'd1);
    check({p, ".busy"}, 32'(busy), 32'd0);
    check({p, ".mem_we"}, 32'(bus.mem_we), 32'd0);
  endtask

  initial begin
    logic [6:0] pat;
    int idx;

    rst          = 1'b1;
    start        = 1'b0;
    run          = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    check_reset("reset");

    // Run without loading; a valid byte in IDLE must be ignored.
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h55;
    run          = 1'b1;
    tick();
    run          = 1'b0;
    bus.rx_valid = 1'b0;
    check("run.cpu_rst", 32'(cpu_rst), 32'd0);
    check("run.done", 32'(done), 32'd1);
    check("run.busy", 32'(busy), 32'd0);
    check("run.rx_ready", 32'(bus.rx_ready), 32'd0);
    tick();
    check("run.no_writes", 32'(wr_count), 32'd0);

    // Load from RUN: status changes the cycle after start.
    do_start();
    check("ld1.cpu_rst", 32'(cpu_rst), 32'd1);
    check("ld1.done", 32'(done), 32'd0);
    check("ld1.busy", 32'(busy), 32'd1);
    check("ld1.rx_ready", 32'(bus.rx_ready), 32'd1);
    pay[0] = 8'h13; pay[1] = 8'h00; pay[2] = 8'h00; pay[3] = 8'h00;
    send_header(8'h04, 8'h00);
    send_stream(4);
    finish_load("ld1");
    check("ld1.wr_count", 32'(wr_count), 32'd4);
    check("ld1.mem0", 32'(mem_model[0]), 32'h13);

    // Zero-length header rejected.
    do_start();
    send_header(8'h00, 8'h00);
    bus.rx_valid = 1'b0;
    check("len0.error", 32'(error), 32'd1);
    check("len0.busy", 32'(busy), 32'd0);
    check("len0.cpu_rst", 32'(cpu_rst), 32'd1);
    check("len0.rx_ready", 32'(bus.rx_ready), 32'd0);
    run = 1'b1;
    tick();
    run = 1'b0;
    check("err.run_ignored", 32'(error), 32'd1);

    // 257 exceeds the 256-byte memory.
    do_start();
    send_header(8'h01, 8'h01);
    bus.rx_valid = 1'b0;
    check("len257.error", 32'(error), 32'd1);
    check("len257.done", 32'(done), 32'd0);
    check("hdr.no_writes", 32'(wr_count), 32'd4);

    // Retry with the largest legal length (256).
    do_start();
    check("retry.error", 32'(error), 32'd0);
    for (int i = 0; i < 256; i++) pay[i] = 8'(i) ^ 8'h5A;
    send_header(8'h00, 8'h01);
    send_stream(256);
    finish_load("ld256");
    check("ld256.wr_count", 32'(wr_count), 32'd260);
    check("ld256.mem0", 32'(mem_model[0]), 32'h5A);
    check("ld256.mem255", 32'(mem_model[255]), 32'hA5);

    // Payload with gaps in rx_valid.
    do_start();
    pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC; pay[3] = 8'hDD;
    send_header(8'h04, 8'h00);
    pat = 7'b1001101;
    idx = 0;
    for (int c = 0; c < 7; c++) begin
      bus.rx_valid = pat[c];
      bus.rx_data  = pat[c] ? pay[idx] : 8'hEE;
      if (pat[c]) run_sum = run_sum + pay[idx];
      tick();
      if (pat[c]) begin
        check($sformatf("gap%0d.we", c), 32'(bus.mem_we), 32'd1);
        check($sformatf("gap%0d.addr", c), bus.mem_waddr, 32'(idx));
        check($sformatf("gap%0d.data", c), 32'(bus.mem_wdata), 32'(pay[idx]));
        idx++;
      end else begin
        check($sformatf("gap%0d.no_we", c), 32'(bus.mem_we), 32'd0);
      end
    end
    finish_load("gap");
    check("gap.wr_count", 32'(wr_count), 32'd264);
    check("gap.mem2", 32'(mem_model[2]), 32'hCC);
    check("gap.mem4_kept", 32'(mem_model[4]), 32'h5E);

    // Reset after two of four payload bytes, then reload.
    do_start();
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
    send_header(8'h04, 8'h00);
    send_stream(2);
    rst          = 1'b1;
    bus.rx_valid = 1'b0;
    tick();
    rst = 1'b0;
    check_reset("midrst");
    do_start();
    pay[0] = 8'h31; pay[1] = 8'h32; pay[2] = 8'h33; pay[3] = 8'h34;
    send_header(8'h04, 8'h00);
    send_stream(4);
    finish_load("reload");
    check("reload.wr_count", 32'(wr_count), 32'd270);
    check("reload.mem0", 32'(mem_model[0]), 32'h31);
    check("reload.mem3", 32'(mem_model[3]), 32'h34);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum: 0x01 + 0x02 + 0xFD == 0 mod 256.
    do_start();
    pay[0] = 8'h01; pay[1] = 8'h02;
    send_header(8'h02, 8'h00);
    send_stream(2);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hFD;
    tick();
    bus.rx_valid = 1'b0;
    check("csum_ok.no_we", 32'(bus.mem_we), 32'd0);
    tick();
    check("csum_ok.done", 32'(done), 32'd1);
    check("csum_ok.cpu_rst", 32'(cpu_rst), 32'd0);

    do_start();
    send_header(8'h02, 8'h00);
    send_stream(2);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hFE;
    tick();
    bus.rx_valid = 1'b0;
    check("csum_bad.error", 32'(error), 32'd1);
    check("csum_bad.cpu_rst", 32'(cpu_rst), 32'd1);
    check("csum_bad.busy", 32'(busy), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
